ahb_request_buffer: RTL

Parametrised per-manager request buffer for the AHB multi-manager interconnect, replacing the single-entry input stage. It queues up to DEPTH address-phase requests from one manager while the arbiter withholds grant. It presents the oldest request to the arbiter and stalls the manager through HREADYOUT only when the queue is full. One instance sits between each manager port and the arbiter/mux.

---
 rtl/ahbspec.sv | 19 +
 rtl/ahb_req_fifo.sv | 70 +++++++
 rtl/flopenl.sv | 18 +
 rtl/flopr.sv | 17 +
 rtl/ahb_request_buffer.sv | 62 ++++++
 5 files changed

// File: rtl/ahbspec.sv
// Shared AHB manager-side request bundle and HTRANS encodings.
package ahbspec;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef struct packed {
    logic [AW-1:0] HADDR;
    logic [DW-1:0] HWDATA;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [1:0]    HTRANS;
  } AHBManager;

endpackage

// File: rtl/ahb_req_fifo.sv
// Request storage: slot array, wrapping head/tail, occupancy and per-slot
// data-pending bits; HWDATA lands in the slot one cycle after its push.
module ahb_req_fifo import ahbspec::*; #(
  parameter int unsigned DEPTH = 2,
  parameter type         TYPE  = AHBManager,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  TYPE           req_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output TYPE           head_o,
  output logic          head_pend_o,
  output logic [CW-1:0] count_o
);

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, cap_idx_q;
  logic [CW-1:0]    count_q, count_d;
  logic             cap_q;
  TYPE              mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    head_d  = wrap_inc(head_q);
    tail_d  = wrap_inc(tail_q);
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (pop_i && !push_i) count_d = count_q - CW'(1);
  end

  flopenl #(.W(PW)) u_head    (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(pop_i),  .d_i(head_d), .q_o(head_q));
  flopenl #(.W(PW)) u_tail    (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(push_i), .d_i(tail_d), .q_o(tail_q));
  flopenl #(.W(PW)) u_cap_idx (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(push_i), .d_i(tail_q), .q_o(cap_idx_q));
  flopr   #(.W(CW)) u_count   (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(count_d), .q_o(count_q));
  flopr   #(.W(1))  u_cap     (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(push_i),  .q_o(cap_q));

  // Push and data capture never target the same slot: the slot just pushed
  // cannot be freed and refilled before its data phase completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && tail_q == PW'(i)) begin
          mem_q[i].HADDR  <= req_i.HADDR;
          mem_q[i].HSIZE  <= req_i.HSIZE;
          mem_q[i].HWRITE <= req_i.HWRITE;
          mem_q[i].HTRANS <= req_i.HTRANS;
          pend_q[i]       <= 1'b1;
        end else if (cap_q && cap_idx_q == PW'(i)) begin
          mem_q[i].HWDATA <= wdata_i;
          pend_q[i]       <= 1'b0;
        end
      end
    end
  end

  assign head_o      = mem_q[head_q];
  assign head_pend_o = pend_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/flopenl.sv
// Load-enable register with asynchronous active-low reset to INIT.
module flopenl #(
  parameter int unsigned   W    = 1,
  parameter logic [W-1:0]  INIT = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   q_o <= INIT;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/flopr.sv
// Register with asynchronous active-low reset to INIT.
module flopr #(
  parameter int unsigned   W    = 1,
  parameter logic [W-1:0]  INIT = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= INIT;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/ahb_request_buffer.sv
// Per-manager AHB request buffer in front of the arbiter.
// Optional empty-queue bypass is enabled by defining AHB_REQ_BYPASS_EN.
module ahb_request_buffer import ahbspec::*; #(
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  AHBManager     inRequest,
  input  logic          HSEL,
  input  logic          GRANT,
  input  logic          HREADY,
  output AHBManager     outRequest,
  output logic          HREADYOUT,
  output logic [CW-1:0] count
);

  AHBManager head_c;
  logic      head_pend_c, head_valid_c, push_c, pop_c, fifo_push_c;

  // Stall depends only on registered occupancy, never on GRANT.
  assign HREADYOUT    = (count != CW'(DEPTH));
  assign push_c       = HSEL & HREADYOUT & (inRequest.HTRANS != HTRANS_IDLE);
  assign head_valid_c = (count != '0) & ~head_pend_c;
  assign pop_c        = head_valid_c & GRANT & HREADY;

`ifdef AHB_REQ_BYPASS_EN
  logic bypass_c, byp_data_q;

  assign bypass_c    = (count == '0) & push_c & GRANT & HREADY;
  assign fifo_push_c = push_c & ~bypass_c;

  flopr #(.W(1)) u_byp (.clk_i(HCLK), .rst_ni(HRESETn), .d_i(bypass_c), .q_o(byp_data_q));

  always_comb begin
    outRequest = head_c;
    if (!head_valid_c) outRequest.HTRANS = HTRANS_IDLE;
    if (bypass_c)      outRequest = inRequest;
    if (byp_data_q)    outRequest.HWDATA = inRequest.HWDATA;
  end
`else
  assign fifo_push_c = push_c;

  always_comb begin
    outRequest = head_c;
    if (!head_valid_c) outRequest.HTRANS = HTRANS_IDLE;
  end
`endif

  ahb_req_fifo #(.DEPTH(DEPTH), .TYPE(AHBManager)) u_fifo (
    .clk_i       (HCLK),
    .rst_ni      (HRESETn),
    .push_i      (fifo_push_c),
    .req_i       (inRequest),
    .wdata_i     (inRequest.HWDATA),
    .pop_i       (pop_c),
    .head_o      (head_c),
    .head_pend_o (head_pend_c),
    .count_o     (count)
  );

endmodule
